// File: rtl/note_pkg.sv
// Shared constants for the twelve-voice square-wave note synthesiser.
// The half-period table is in 50 MHz clock cycles for octave 4.
package note_pkg;

  localparam int unsigned NUM_NOTES = 12;
  localparam int unsigned SAMPLE_W  = 24;
  localparam int unsigned CNT_W     = 17;
  localparam int unsigned MIX_W     = 28;
  localparam int unsigned VOICE_W   = 4;

  localparam int unsigned NOTE_C  = 0;
  localparam int unsigned NOTE_CS = 1;
  localparam int unsigned NOTE_D  = 2;
  localparam int unsigned NOTE_DS = 3;
  localparam int unsigned NOTE_E  = 4;
  localparam int unsigned NOTE_F  = 5;
  localparam int unsigned NOTE_FS = 6;
  localparam int unsigned NOTE_G  = 7;
  localparam int unsigned NOTE_GS = 8;
  localparam int unsigned NOTE_A  = 9;
  localparam int unsigned NOTE_AS = 10;
  localparam int unsigned NOTE_B  = 11;

  typedef logic [CNT_W-1:0] half_t;

  localparam half_t HALF [NUM_NOTES] = '{
    17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843, 17'd71586,
    17'd67568, 17'd63776, 17'd60196, 17'd56818, 17'd53629, 17'd50619
  };

  // Output handshake start-up: sample_valid rises on the third edge after reset.
  typedef enum logic [1:0] {
    ST_WAIT0,
    ST_WAIT1,
    ST_WAIT2,
    ST_RUN
  } start_e;

  localparam logic signed [MIX_W-1:0] MIX_MAX = MIX_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [MIX_W-1:0] MIX_MIN = MIX_W'(-(2 ** (SAMPLE_W - 1)));

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [MIX_W-1:0] x);
    if (x > MIX_MAX) begin
      return {1'b0, {(SAMPLE_W - 1){1'b1}}};
    end else if (x < MIX_MIN) begin
      return {1'b1, {(SAMPLE_W - 1){1'b0}}};
    end else begin
      return x[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/note_voice.sv
// One square-wave voice: half-period counter plus output level.
// Releasing the note parks the voice at phase 0, positive half.
module note_voice
  import note_pkg::*;
#(
  parameter half_t HALF_CNT = 17'd56818
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held,
  output logic level
);

  localparam half_t LAST = HALF_CNT - half_t'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Release is tested first so it overrides a wrap on the same edge.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (!held) begin
      cnt_d   = '0;
      level_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + half_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/note_synth.sv
// Twelve-voice note synthesiser: synchronised note inputs, per-note square
// voices, registered saturating mixer and a ready/valid sample output.
module note_synth
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned AMP    = 600000
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic [NUM_NOTES-1:0]       notes,
  input  logic                       sample_ready,
  output logic                       sample_valid,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic [VOICE_W-1:0]         voices
);

  if (CLK_HZ == 0) begin : g_bad_clk
    $error("note_synth: CLK_HZ must be non-zero");
  end

  localparam logic signed [MIX_W-1:0] AMP_S = MIX_W'(AMP);

  logic [NUM_NOTES-1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_NOTES-1:0]       level;
  logic signed [MIX_W-1:0]    mix_q, mix_d;
  logic [VOICE_W-1:0]         voices_q, voices_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  start_e                     state_q, state_d;

  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_voice
    note_voice #(
      .HALF_CNT(HALF[i])
    ) u_voice (
      .clk  (CLOCK_50),
      .rst_n(resetn),
      .held (sync2_q[i]),
      .level(level[i])
    );
  end

  always_comb begin
    sync1_d = notes;
    sync2_d = sync1_q;
  end

  always_comb begin
    mix_d    = '0;
    voices_d = '0;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      if (sync2_q[i]) begin
        mix_d    = level[i] ? (mix_d + AMP_S) : (mix_d - AMP_S);
        voices_d = voices_d + VOICE_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT0: state_d = ST_WAIT1;
      ST_WAIT1: state_d = ST_WAIT2;
      ST_WAIT2: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_WAIT0;
    endcase
  end

  // Before the first valid, and on every transfer, take the live mix.
  always_comb begin
    sample_d = sample_q;
    if ((state_q != ST_RUN) || sample_ready) begin
      sample_d = sat_sample(mix_q);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      mix_q    <= '0;
      voices_q <= '0;
      sample_q <= '0;
      state_q  <= ST_WAIT0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      mix_q    <= mix_d;
      voices_q <= voices_d;
      sample_q <= sample_d;
      state_q  <= state_d;
    end
  end

  assign sample_valid = (state_q == ST_RUN);
  assign sample       = sample_q;
  assign voices       = voices_q;

endmodule

// File: tb/tb_note_synth.sv
// Bench for note_synth: vector table, directed multi-cycle sequences and
// random notes/ready checked every cycle against a phase-age reference model.
module tb_note_synth;

  localparam int AMP = 600000;
  localparam int HALF_T [12] = '{95556, 90193, 85131, 80353, 75843, 71586,
                                 67568, 63776, 60196, 56818, 53629, 50619};

  logic               CLOCK_50;
  logic               resetn;
  logic [11:0]        notes;
  logic               sample_ready;
  logic               sample_valid;
  logic signed [23:0] sample;
  logic [3:0]         voices;

  note_synth #(
    .CLK_HZ(50000000),
    .AMP   (AMP)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .notes       (notes),
    .sample_ready(sample_ready),
    .sample_valid(sample_valid),
    .sample      (sample),
    .voices      (voices)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: each voice is described by how many cycles it has been
  // sounding; its sign is the parity of age / HALF.
  int        m_age [12];
  bit [11:0] m_s1, m_s2;
  int        m_mix, m_sample, m_voices, m_edges;
  bit        m_valid;
  int        n_mix, n_vc, n_smp;

  function automatic int sat24(input int x);
    if (x > 8388607) return 8388607;
    if (x < -8388608) return -8388608;
    return x;
  endfunction

  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 12; i++) m_age[i] = 0;
      m_s1 = '0; m_s2 = '0;
      m_mix = 0; m_sample = 0; m_voices = 0; m_edges = 0; m_valid = 1'b0;
    end else begin
      n_mix = 0;
      for (int i = 0; i < 12; i++)
        if (m_s2[i]) n_mix += (((m_age[i] / HALF_T[i]) % 2) == 0) ? AMP : -AMP;
      n_vc  = $countones(m_s2);
      n_smp = (!m_valid || sample_ready) ? sat24(m_mix) : m_sample;
      for (int i = 0; i < 12; i++) m_age[i] = m_s2[i] ? m_age[i] + 1 : 0;
      m_s2 = m_s1;
      m_s1 = notes;
      m_mix = n_mix;
      m_voices = n_vc;
      m_sample = n_smp;
      m_edges++;
      m_valid = (m_edges >= 3);
    end
  end

  int n_cmp, n_bad, cyc_n;
  bit mchk;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    @(negedge CLOCK_50);
    cyc_n++;
    if (mchk) begin
      chk("model_sample", sample, m_sample);
      chk("model_valid", sample_valid, m_valid);
      chk("model_voices", voices, m_voices);
    end
  endtask

  typedef struct {
    logic [11:0] nt;
    int          vc;
    int          exp;
  } vec_t;

  vec_t vt [6];
  int   t_press, t0, t1;

  initial begin
    n_cmp = 0; n_bad = 0; cyc_n = 0; mchk = 1'b0;
    notes = '0; sample_ready = 1'b1;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_voices", voices, 0);

    // Startup: valid on the third edge after release, idle output is zero.
    @(negedge CLOCK_50);
    resetn = 1'b1;
    mchk = 1'b1;
    cyc(); chk("start_valid_e1", sample_valid, 0);
    cyc(); chk("start_valid_e2", sample_valid, 0);
    cyc(); chk("start_valid_e3", sample_valid, 1);
    chk("idle_sample", sample, 0);
    chk("idle_voices", voices, 0);
    repeat (5) cyc();

    // Fresh presses: voices after 3 edges, first sample after 4 edges.
    vt[0] = '{12'h200, 1, 600000};
    vt[1] = '{12'hFFF, 12, 7200000};
    vt[2] = '{12'h011, 2, 1200000};
    vt[3] = '{12'h000, 0, 0};
    vt[4] = '{12'h555, 6, 3600000};
    vt[5] = '{12'h800, 1, 600000};
    for (int k = 0; k < 6; k++) begin
      notes = '0;
      repeat (6) cyc();
      notes = vt[k].nt;
      cyc(); cyc();
      chk("vec_voices_e2", voices, 0);
      chk("vec_sample_e2", sample, 0);
      cyc();
      chk("vec_voices_e3", voices, vt[k].vc);
      chk("vec_sample_e3", sample, 0);
      cyc();
      chk("vec_sample_e4", sample, vt[k].exp);
    end

    // Backpressure: output frozen while notes change, then takes the live mix.
    notes = '0;
    repeat (6) cyc();
    notes = 12'h200;
    repeat (6) cyc();
    chk("pre_freeze", sample, 600000);
    sample_ready = 1'b0;
    notes = 12'h201;
    repeat (100) cyc();
    chk("freeze_hold", sample, 600000);
    chk("freeze_valid", sample_valid, 1);
    chk("freeze_voices", voices, 2);
    sample_ready = 1'b1;
    cyc();
    chk("unfreeze_current", sample, 1200000);

    // A and B together; B released so its release lands on its wrap edge.
    notes = '0;
    repeat (6) cyc();
    notes = 12'hA00;
    t_press = cyc_n;
    t0 = -1;
    for (int k = 0; k < HALF_T[11] - 1; k++) begin
      cyc();
      if (t0 < 0 && sample != 0) t0 = cyc_n;
    end
    notes = 12'h200;
    chk("first_nonzero_lat", t0 - t_press, 4);
    repeat (20) cyc();
    chk("b_released", sample, 600000);
    notes = 12'hA00;
    repeat (5) cyc();
    chk("b_repress_level1", sample, 1200000);
    t1 = -1;
    for (int k = 0; k < 20000; k++) begin
      cyc();
      if (sample == 0) begin
        t1 = cyc_n;
        break;
      end
    end
    chk("a_half_period", t1 - t0, 56818);
    notes = 12'h200;
    repeat (5) cyc();
    chk("a_negative", sample, -600000);

    // Random notes and ready.
    for (int s = 0; s < 150; s++) begin
      notes = 12'($urandom);
      repeat ($urandom_range(1, 30)) begin
        sample_ready = ($urandom_range(0, 3) != 0);
        cyc();
      end
    end

    // Asynchronous reset mid-tone, then recovery.
    sample_ready = 1'b1;
    notes = 12'hFFF;
    repeat (10) cyc();
    chk("pre_reset_voices", voices, 12);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_sample", sample, 0);
    chk("async_rst_valid", sample_valid, 0);
    chk("async_rst_voices", voices, 0);
    notes = '0;
    repeat (2) cyc();
    resetn = 1'b1;
    cyc(); chk("recover_valid_e1", sample_valid, 0);
    cyc(); chk("recover_valid_e2", sample_valid, 0);
    cyc(); chk("recover_valid_e3", sample_valid, 1);
    chk("recover_sample", sample, 0);
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_synth.md
NOTE_SYNTH -- requirements
Module: note_synth

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency; it documents the clock the half-period table is computed for.
REQ-002 Parameter AMP, default 600000, per-voice square-wave amplitude (signed 24-bit magnitude).
REQ-003 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 notes  input  12  note-held bits from the recording/playback stage; bit order [0]=C,[1]=C#,[2]=D,[3]=D#,[4]=E,[5]=F,[6]=F#,[7]=G,[8]=G#,[9]=A,[10]=A#,[11]=B; asynchronous to the sample handshake.
REQ-006 sample_ready  input  1  audio codec FIFO can accept a sample.
REQ-007 sample_valid  output  1  sample holds a valid mixed value.
REQ-008 sample  output  24  signed two's-complement mixed audio sample.
REQ-009 voices  output  4  count of currently sounding notes (0..12).

Function
REQ-010 notes SHALL pass through a 2-flop synchroniser before any use; "held" means the synchronised bit is 1.
REQ-011 Each voice SHALL own a 17-bit half-period counter and a 1-bit level; constant HALF[i] = {95556,90193,85131,80353,75843,71586,67568,63776,60196,56818,53629,50619} (octave 4, 50 MHz).
REQ-012 While held: counter increments each cycle; when counter == HALF[i]-1 it wraps to 0 and level toggles on the same edge.
REQ-013 While not held: counter forced to 0 and level forced to 1, so every press starts at phase 0, positive half.
REQ-014 Voice contribution SHALL be +AMP when held and level=1, -AMP when held and level=0, 0 when not held.
REQ-015 Mixer SHALL sum the 12 contributions in at least 28-bit signed arithmetic into a registered mix (one cycle after voice state), then saturate to [-8388608, 8388607] before use.
REQ-016 voices SHALL be the registered popcount of held bits, aligned with the mix register.
REQ-017 Output register: loads the saturated mix when sample_valid=0 or (sample_valid=1 and sample_ready=1); otherwise holds sample unchanged.
REQ-018 sample_valid SHALL rise at the 3rd rising edge after resetn deasserts and then stay 1; a transfer occurs on every edge with sample_valid=1 and sample_ready=1.
REQ-019 Latency: change of notes to change of sample SHALL be 4 cycles when sample_ready stays 1 (2 sync + mix + output).
REQ-020 sample_ready held low SHALL freeze sample indefinitely while voice counters continue running; no accumulation of missed samples.
REQ-021 Simultaneous release and wrap on the same edge: release wins (counter 0, level 1).

Reset
REQ-022 resetn low SHALL immediately clear: synchronisers 0, all counters 0, all levels 1, mix 0, voices 0, sample 0, sample_valid 0.
REQ-023 Reset asserted mid-note or mid-handshake SHALL abandon the pending sample; no transfer is reported until REQ-018 timing recurs.

Structure
REQ-024 Shared package note_pkg SHALL hold NUM_NOTES=12, the note index constants, HALF table, and SAMPLE_W=24.
REQ-025 One sub-module note_voice (counter+level for one note, HALF as parameter) instantiated 12 times; mixer, popcount and output register in note_synth.

Verification
REQ-026 Reset then idle, ready=1: sample_valid=1 from 3rd edge, sample=0, voices=0.
REQ-027 notes=bit9 (A) held, ready=1: sample=+600000 for 56818 cycles, then -600000 for 56818, period 113636 cycles; voices=1, first nonzero sample 4 cycles after input change.
REQ-028 All 12 held at once: first sample=+7200000, voices=12; each voice toggles at its own HALF count.
REQ-029 A held, ready=0 for 100000 cycles: sample frozen at value of last transfer; on ready=1, next edge transfers current mix, not a stale queue.
REQ-030 Release A exactly at its wrap cycle, then re-press: voice restarts with level 1, first half-period exactly 56818 cycles.
REQ-031 resetn pulsed low mid-tone: all outputs 0 asynchronously, before the next clock edge; recovery per REQ-026.
